// File: rtl/fft_frame_sequencer.sv
// fft_frame_sequencer
//   Frame-level controller for the pitch-detect FFT path. Waits for a full
//   frame in the input buffer, reads it out as one contiguous NSamples burst
//   (which, delayed by the buffer read latency, becomes the FFT input enable),
//   counts the NSamples output bins, then captures the peak bin index into a
//   valid/ready output register. Output back-pressure never stalls the FSM.
//
// Ports
//   clk, reset    system clock, synchronous active-high reset
//   frame_ready   input buffer holds a complete frame
//   frame_ack     1-cycle pulse: frame consumed, buffer may refill
//   rd_en/rd_addr buffer read strobe / address
//   fft_di_en     FFT input enable (rd_en delayed by RD_LAT cycles)
//   fft_do_en     FFT output-bin valid
//   peak_valid    peak finder result strobe, with peak_k = peak bin index
//   pitch_valid/pitch_ready/pitch_data   result output, valid/ready handshake
//   busy          FSM is not in IDLE (state visibility for checkers)
//   overrun       sticky: an unread result was overwritten
//   timeout_err   sticky: watchdog fired
//
// Handshake: a result transfers in any cycle where pitch_valid and
// pitch_ready are both high; pitch_data is stable while pitch_valid is high
// unless a newer result overwrites it (flagged by overrun).
//
// Configuration macro: SEQ_TIMEOUT_EN enables a watchdog on the WAIT_OUT and
// WAIT_PEAK states. Without it timeout_err is tied low and the FSM waits
// indefinitely for bins and the peak.
module fft_frame_sequencer #(
  parameter int NSamples    = 1024,
  parameter int W           = 16,
  parameter int RD_LAT      = 1,
  parameter int TIMEOUT_CYC = 8192
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        frame_ready,
  output logic                        frame_ack,
  output logic                        rd_en,
  output logic [$clog2(NSamples)-1:0] rd_addr,
  output logic                        fft_di_en,
  input  logic                        fft_do_en,
  input  logic                        peak_valid,
  input  logic [W-1:0]                peak_k,
  output logic                        pitch_valid,
  input  logic                        pitch_ready,
  output logic [W-1:0]                pitch_data,
  output logic                        busy,
  output logic                        overrun,
  output logic                        timeout_err
);

  localparam int AW = $clog2(NSamples);

  if (NSamples < 4 || (NSamples & (NSamples - 1)) != 0 || RD_LAT < 0 || RD_LAT > 3 ||
      TIMEOUT_CYC < 2) begin : g_bad_params
    $error("fft_frame_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FEED      = 2'd1,
    WAIT_OUT  = 2'd2,
    WAIT_PEAK = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   bin_q, bin_d;
  logic            capture;
  logic            wd_fire;
  logic            wd_trip;
  logic            pitch_valid_q;
  logic [W-1:0]    pitch_data_q;
  logic            overrun_q;

  // Next-state and strobe logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    bin_d     = bin_q;
    frame_ack = 1'b0;
    rd_en     = 1'b0;
    capture   = 1'b0;
    wd_trip   = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_ready) begin
          state_d = FEED;
          addr_d  = '0;
          bin_d   = '0;
        end
      end
      FEED: begin
        rd_en  = 1'b1;
        addr_d = addr_q + 1'b1;   // wraps back to 0 after the last sample
        if (fft_do_en) bin_d = bin_q + 1'b1;
        if (addr_q == AW'(NSamples - 1)) begin
          frame_ack = 1'b1;
          state_d   = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        // A bin arriving in the same cycle the watchdog expires wins.
        if (fft_do_en) begin
          bin_d = bin_q + 1'b1;
          if (bin_q == AW'(NSamples - 1)) state_d = WAIT_PEAK;
        end else if (wd_fire) begin
          wd_trip = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_PEAK: begin
        if (peak_valid) begin
          capture = 1'b1;
          state_d = IDLE;
        end else if (wd_fire) begin
          wd_trip = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      bin_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      bin_q   <= bin_d;
    end
  end

  assign rd_addr = addr_q;
  assign busy    = (state_q != IDLE);

  // Read-latency matching: the delay line runs continuously so the tail of
  // the burst drains after the FSM has already moved to WAIT_OUT.
  if (RD_LAT == 0) begin : g_dly_none
    assign fft_di_en = rd_en;
  end else begin : g_dly
    logic [RD_LAT-1:0] dly_q;
    always_ff @(posedge clk) begin
      if (reset) dly_q <= '0;
      else       dly_q <= (dly_q << 1) | RD_LAT'(rd_en);
    end
    assign fft_di_en = dly_q[RD_LAT-1];
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC);
  logic [WD_W-1:0] wd_q;
  logic            timeout_err_q;

  // Restarts on entry to WAIT_OUT (the frame_ack cycle) and on every bin.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (frame_ack || fft_do_en)                        wd_q <= '0;
      else if (state_q == WAIT_OUT || state_q == WAIT_PEAK) wd_q <= wd_q + 1'b1;
      if (wd_trip) timeout_err_q <= 1'b1;
    end
  end

  assign wd_fire     = (wd_q == WD_W'(TIMEOUT_CYC - 1));
  assign timeout_err = timeout_err_q;
`else
  assign wd_fire     = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Result register. A new capture always wins over a same-cycle handshake;
  // it only counts as an overrun if the old value was not being taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      pitch_valid_q <= 1'b0;
      pitch_data_q  <= '0;
      overrun_q     <= 1'b0;
    end else if (capture) begin
      pitch_data_q  <= peak_k;
      pitch_valid_q <= 1'b1;
      if (pitch_valid_q && !pitch_ready) overrun_q <= 1'b1;
    end else if (pitch_valid_q && pitch_ready) begin
      pitch_valid_q <= 1'b0;
    end
  end

  assign pitch_valid = pitch_valid_q;
  assign pitch_data  = pitch_data_q;
  assign overrun     = overrun_q;

endmodule
